// File: rtl/alu_pkg.sv
// Shared opcode constants, FSM state encoding and opcode helpers for the
// bit-serial ALU controller and its one-bit slice.
package alu_pkg;

    localparam logic [2:0] OP_AND = 3'b001;
    localparam logic [2:0] OP_OR  = 3'b010;
    localparam logic [2:0] OP_ADD = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b100;
    localparam logic [2:0] OP_NOR = 3'b101;
    localparam logic [2:0] OP_SLT = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    function automatic logic op_legal(input logic [2:0] op);
        return (op == OP_AND) || (op == OP_OR) || (op == OP_ADD) ||
               (op == OP_SUB) || (op == OP_NOR) || (op == OP_SLT);
    endfunction

    function automatic logic op_inv_b(input logic [2:0] op);
        return (op == OP_SUB) || (op == OP_SLT);
    endfunction

endpackage

// File: rtl/alu_serial_ctrl_if.sv
// Start/done request bus of the bit-serial ALU; ALU_SERIAL_OPERR_EN adds op_err.
interface alu_serial_ctrl_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] src1;
    logic [WIDTH-1:0] src2;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             cout;
    logic             overflow;
`ifdef ALU_SERIAL_OPERR_EN
    logic             op_err;
`endif

    modport master (
`ifdef ALU_SERIAL_OPERR_EN
        input  op_err,
`endif
        output start, op, src1, src2,
        input  busy, done, result, zero, cout, overflow
    );

    modport slave (
`ifdef ALU_SERIAL_OPERR_EN
        output op_err,
`endif
        input  start, op, src1, src2,
        output busy, done, result, zero, cout, overflow
    );
endinterface

// File: rtl/alu_serial_bit.sv
// Combinational one-bit ALU slice: logic ops on a/b, full add of a and (b ^ b_inv).
module alu_serial_bit
    import alu_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       b_inv,
    input  logic       cin,
    input  logic [2:0] op,
    output logic       r,
    output logic       cout
);

    logic bb;
    logic sum;
    logic carry;

    always_comb begin
        bb    = b ^ b_inv;
        sum   = a ^ bb ^ cin;
        carry = (a & bb) | (cin & (a ^ bb));
        r     = 1'b0;
        cout  = 1'b0;
        case (op)
            OP_AND: r = a & b;
            OP_OR:  r = a | b;
            OP_NOR: r = ~(a | b);
            OP_ADD, OP_SUB, OP_SLT: begin
                r    = sum;
                cout = carry;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_serial_ctrl.sv
// Bit-serial ALU sequencer driving one alu_serial_bit slice LSB-first.
// Optional macro ALU_SERIAL_OPERR_EN: op_err output, illegal opcodes skip RUN.
module alu_serial_ctrl
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_serial_ctrl_if.slave  bus
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sh_q, sh_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [2:0]       op_q, op_d;
    logic             c_q, c_d;
    logic             fin_c_q, fin_c_d, fin_ov_q, fin_ov_d;
    logic             zero_q, zero_d, cout_q, cout_d, overflow_q, overflow_d;
    logic             bit_r, bit_c;
`ifdef ALU_SERIAL_OPERR_EN
    logic             op_err_q, op_err_d;
`endif

    alu_serial_bit u_bit (
        .a     (a_q[0]),
        .b     (b_q[0]),
        .b_inv (op_inv_b(op_q)),
        .cin   (c_q),
        .op    (op_q),
        .r     (bit_r),
        .cout  (bit_c)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        a_d        = a_q;
        b_d        = b_q;
        sh_d       = sh_q;
        op_d       = op_q;
        c_d        = c_q;
        fin_c_d    = fin_c_q;
        fin_ov_d   = fin_ov_q;
        result_d   = result_q;
        zero_d     = zero_q;
        cout_d     = cout_q;
        overflow_d = overflow_q;
`ifdef ALU_SERIAL_OPERR_EN
        op_err_d   = op_err_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    a_d     = bus.src1;
                    b_d     = bus.src2;
                    op_d    = bus.op;
                    cnt_d   = '0;
                    c_d     = op_inv_b(bus.op);
                    state_d = S_RUN;
`ifdef ALU_SERIAL_OPERR_EN
                    if (!op_legal(bus.op)) begin
                        state_d    = S_DONE;
                        result_d   = '0;
                        zero_d     = 1'b1;
                        cout_d     = 1'b0;
                        overflow_d = 1'b0;
                        op_err_d   = 1'b1;
                    end
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                cnt_d = cnt_q + 1'b1;
                // Counter runs one past the MSB: the extra cycle publishes
                // result/flags (SLT sign fix needs the latched MSB carries).
                if (cnt_q == CNT_W'(WIDTH)) begin
                    state_d    = S_DONE;
                    cout_d     = 1'b0;
                    overflow_d = 1'b0;
`ifdef ALU_SERIAL_OPERR_EN
                    op_err_d   = 1'b0;
`endif
                    case (op_q)
                        OP_ADD, OP_SUB: begin
                            result_d   = sh_q;
                            cout_d     = fin_c_q;
                            overflow_d = fin_ov_q;
                        end
                        OP_SLT:                 result_d = {{(WIDTH-1){1'b0}}, sh_q[WIDTH-1] ^ fin_ov_q};
                        OP_AND, OP_OR, OP_NOR:  result_d = sh_q;
                        default:                result_d = '0;
                    endcase
                    zero_d = (result_d == '0);
                end else begin
                    a_d  = a_q >> 1;
                    b_d  = b_q >> 1;
                    sh_d = {bit_r, sh_q[WIDTH-1:1]};
                    c_d  = bit_c;
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        fin_c_d  = bit_c;
                        fin_ov_d = c_q ^ bit_c;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            sh_q       <= '0;
            op_q       <= '0;
            c_q        <= 1'b0;
            fin_c_q    <= 1'b0;
            fin_ov_q   <= 1'b0;
            result_q   <= '0;
            zero_q     <= 1'b0;
            cout_q     <= 1'b0;
            overflow_q <= 1'b0;
`ifdef ALU_SERIAL_OPERR_EN
            op_err_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            a_q        <= a_d;
            b_q        <= b_d;
            sh_q       <= sh_d;
            op_q       <= op_d;
            c_q        <= c_d;
            fin_c_q    <= fin_c_d;
            fin_ov_q   <= fin_ov_d;
            result_q   <= result_d;
            zero_q     <= zero_d;
            cout_q     <= cout_d;
            overflow_q <= overflow_d;
`ifdef ALU_SERIAL_OPERR_EN
            op_err_q   <= op_err_d;
`endif
        end
    end

    assign bus.busy     = (state_q == S_RUN);
    assign bus.done     = (state_q == S_DONE);
    assign bus.result   = result_q;
    assign bus.zero     = zero_q;
    assign bus.cout     = cout_q;
    assign bus.overflow = overflow_q;
`ifdef ALU_SERIAL_OPERR_EN
    assign bus.op_err   = op_err_q;
`endif

endmodule
